// File: rtl/uart_reg_pkg.sv
// Shared UART register-level package.
// Holds the TX arbiter FSM state type and the default sizing constants used by
// the arbiter, its interface and the round-robin picker.
package uart_reg_pkg;

    // Arbiter FSM: ARB searches for an owner, XFER streams the owner's packet.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } uart_arb_st_e;

    // Default number of byte-stream requesters sharing the TX FIFO.
    localparam int UartArbNumReq        = 4;
    // Default stall budget (owner valid low) before a packet is aborted.
    localparam int UartArbTimeoutCycles = 1024;
    // Depth of the UART core TX FIFO; the arbiter's credit limit.
    localparam int TxFifoDepth          = 32;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX FIFO write bundle for uart_tx_arbiter.
// Signals:
//   req_valid_i / req_data_i / req_last_i / req_en_i : requester side, one lane per requester
//                                                      (byte lane i in req_data_i[8i+7:8i])
//   req_ready_o                                      : per-requester byte accept
//   fifo_lvl_i                                       : current TX FIFO level
//   fifo_wvalid_o / fifo_wdata_o                     : TX FIFO write strobe and byte
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters plus UART core)
interface uart_tx_arbiter_if #(
    parameter int NumReq = uart_reg_pkg::UartArbNumReq
);
    logic [NumReq-1:0]   req_valid_i;
    logic [NumReq*8-1:0] req_data_i;
    logic [NumReq-1:0]   req_last_i;
    logic [NumReq-1:0]   req_ready_o;
    logic [NumReq-1:0]   req_en_i;
    logic [7:0]          fifo_lvl_i;
    logic                fifo_wvalid_o;
    logic [7:0]          fifo_wdata_o;

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, req_en_i, fifo_lvl_i,
        output req_ready_o, fifo_wvalid_o, fifo_wdata_o
    );

    modport master (
        output req_valid_i, req_data_i, req_last_i, req_en_i, fifo_lvl_i,
        input  req_ready_o, fifo_wvalid_o, fifo_wdata_o
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority picker.
// Scans the request vector starting at ptr and wrapping around; the first set
// bit wins.
// Ports:
//   req   : request vector
//   ptr   : index where the search starts
//   gnt   : one-hot winner (0 when no request)
//   idx   : binary index of the winner (0 when no request)
//   found : at least one request was set
module uart_rr_pick #(
    parameter  int N    = uart_reg_pkg::UartArbNumReq,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            found
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART TX FIFO write port.
// One requester owns the FIFO for a whole packet; writes are throttled by a
// credit check against the FIFO level, and a stall watchdog aborts a packet
// whose owner stops presenting bytes.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : requester lanes and TX FIFO write/level (slave modport)
//   flush_i       : abort the current packet, no error
//   grant_o       : one-hot current owner, 0 in ARB
//   busy_o        : packet in progress (state XFER)
//   timeout_err_o : one-cycle pulse when the watchdog aborts a packet
//   timeout_id_o  : requester that last timed out, held until the next timeout
module uart_tx_arbiter
    import uart_reg_pkg::*;
#(
    parameter  int NumReq        = UartArbNumReq,
    parameter  int FifoDepth     = TxFifoDepth,
    parameter  int TimeoutCycles = UartArbTimeoutCycles,
    localparam int IdxW          = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int CntW          = $clog2(TimeoutCycles + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    uart_tx_arbiter_if.slave  bus,
    input  logic              flush_i,
    output logic [NumReq-1:0] grant_o,
    output logic              busy_o,
    output logic              timeout_err_o,
    output logic [IdxW-1:0]   timeout_id_o
);

    localparam logic [0:0] StArb  = ARB;
    localparam logic [0:0] StXfer = XFER;

    logic [0:0]        state;
    logic [IdxW-1:0]   rr_ptr;
    logic [IdxW-1:0]   owner;
    logic [NumReq-1:0] grant_q;
    logic [CntW-1:0]   wd_cnt;
    logic              fifo_wvalid_q;
    logic [7:0]        fifo_wdata_q;
    logic              timeout_err_q;
    logic [IdxW-1:0]   timeout_id_q;

    logic [NumReq-1:0] cand;
    logic [NumReq-1:0] pick_gnt;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_found;

    logic              xfer;
    logic              owner_valid;
    logic              owner_last;
    logic [7:0]        owner_data;
    logic [8:0]        lvl_sum;
    logic              credit_ok;
    logic              hs;
    logic              stalled;
    logic              wd_hit;
    logic [IdxW-1:0]   rr_after;

    assign cand = bus.req_valid_i & bus.req_en_i;

    uart_rr_pick #(.N(NumReq)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign xfer        = (state == StXfer);
    assign owner_valid = bus.req_valid_i[owner];
    assign owner_last  = bus.req_last_i[owner];
    assign owner_data  = bus.req_data_i[8*owner +: 8];

    // The registered strobe is a byte the FIFO has not counted yet, so it is
    // charged against the credit alongside the reported level.
    assign lvl_sum   = {1'b0, bus.fifo_lvl_i} + {8'd0, fifo_wvalid_q};
    assign credit_ok = (lvl_sum < 9'(FifoDepth));

    assign hs      = xfer && owner_valid && credit_ok;
    // Only an absent owner counts as a stall; a full FIFO never trips the watchdog.
    assign stalled = xfer && !owner_valid;
    // Abort on the stall cycle that would bring the count to TimeoutCycles.
    assign wd_hit  = stalled && (wd_cnt == CntW'(TimeoutCycles - 1));

    assign rr_after = (owner == IdxW'(NumReq - 1)) ? '0 : owner + 1'b1;

    // Ready may be high while the owner's valid is low; it only reflects credit.
    always_comb begin
        bus.req_ready_o = '0;
        if (xfer && credit_ok) begin
            bus.req_ready_o[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state         <= StArb;
            rr_ptr        <= '0;
            owner         <= '0;
            grant_q       <= '0;
            wd_cnt        <= '0;
            fifo_wvalid_q <= 1'b0;
            fifo_wdata_q  <= '0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '0;
        end else begin
            fifo_wvalid_q <= hs;
            timeout_err_q <= 1'b0;
            if (hs) begin
                fifo_wdata_q <= owner_data;
            end

            if (state == StArb) begin
                wd_cnt <= '0;
                if (pick_found) begin
                    state   <= StXfer;
                    owner   <= pick_idx;
                    grant_q <= pick_gnt;
                end
            end else begin
                if (hs) begin
                    wd_cnt <= '0;
                end else if (stalled) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end

                // Flush outranks both packet end and timeout; a byte accepted
                // in the flush cycle has already been strobed above.
                if (flush_i) begin
                    state   <= StArb;
                    grant_q <= '0;
                    wd_cnt  <= '0;
                end else if (hs && owner_last) begin
                    state   <= StArb;
                    grant_q <= '0;
                    rr_ptr  <= rr_after;
                end else if (wd_hit) begin
                    state         <= StArb;
                    grant_q       <= '0;
                    rr_ptr        <= rr_after;
                    wd_cnt        <= '0;
                    timeout_err_q <= 1'b1;
                    timeout_id_q  <= owner;
                end
            end
        end
    end

    assign grant_o           = grant_q;
    assign busy_o            = xfer;
    assign timeout_err_o     = timeout_err_q;
    assign timeout_id_o      = timeout_id_q;
    assign bus.fifo_wvalid_o = fifo_wvalid_q;
    assign bus.fifo_wdata_o  = fifo_wdata_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (4 requesters, 32-deep FIFO,
// 16-cycle watchdog). Requester lanes are driven from per-lane byte lists;
// expected FIFO bytes go into a scoreboard queue in predicted arbitration
// order and are popped when the DUT strobes a write.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int FD = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [NR-1:0] grant;
    logic          busy;
    logic          terr;
    logic [1:0]    tid;

    uart_tx_arbiter_if #(.NumReq(NR)) bus ();

    uart_tx_arbiter #(
        .NumReq        (NR),
        .FifoDepth     (FD),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bus           (bus),
        .flush_i       (flush),
        .grant_o       (grant),
        .busy_o        (busy),
        .timeout_err_o (terr),
        .timeout_id_o  (tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of bytes the FIFO must receive, in order.
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.fifo_wvalid_o) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("wr_unexpected", 32'(bus.fifo_wdata_o), 32'hFFFF_FFFF);
            else                   check("wr_data", 32'(bus.fifo_wdata_o), 32'(exp_q.pop_front()));
        end
    end

    // Per-requester byte lists.
    logic [7:0] pkt_data[NR][16];
    logic       pkt_last[NR][16];
    int         pkt_len[NR];
    int         pkt_pos[NR];

    task automatic drive_lanes();
        for (int r = 0; r < NR; r++) begin
            if (pkt_pos[r] < pkt_len[r]) begin
                bus.req_valid_i[r]        = 1'b1;
                bus.req_data_i[8*r +: 8]  = pkt_data[r][pkt_pos[r]];
                bus.req_last_i[r]         = pkt_last[r][pkt_pos[r]];
            end else begin
                bus.req_valid_i[r]        = 1'b0;
                bus.req_data_i[8*r +: 8]  = 8'h00;
                bus.req_last_i[r]         = 1'b0;
            end
        end
    endtask

    task automatic clear_lanes();
        for (int r = 0; r < NR; r++) begin
            pkt_len[r] = 0;
            pkt_pos[r] = 0;
        end
        drive_lanes();
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        pkt_data[r][pkt_len[r]] = d;
        pkt_last[r][pkt_len[r]] = l;
        pkt_len[r]++;
    endtask

    function automatic logic lanes_pending();
        for (int r = 0; r < NR; r++) begin
            if (pkt_pos[r] < pkt_len[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: handshakes are sampled mid-cycle, lanes advance #1 after the edge.
    task automatic tick();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = bus.req_valid_i & bus.req_ready_o;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (hs[r]) pkt_pos[r]++;
        end
        drive_lanes();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        clear_lanes();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || lanes_pending()) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check(tag, 32'(n < 100), 32'd1);
    endtask

    logic [NR-1:0] gseq[$];
    logic [NR-1:0] rr_exp[5];
    logic [NR-1:0] prev_g;
    int            gap_viol;
    int            wr_base;
    int            n;
    logic          ready_seen;
    logic          terr_seen;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.req_en_i    = '1;
        bus.fifo_lvl_i  = 8'd0;
        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        bus.req_last_i  = '0;
        clear_lanes();
        do_reset();

        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready_o), 32'd0);
        check("rst_wvalid", 32'(bus.fifo_wvalid_o), 32'd0);

        // Single packet from requester 1.
        add_byte(1, 8'h41, 1'b0);
        add_byte(1, 8'h42, 1'b0);
        add_byte(1, 8'h43, 1'b1);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        drive_lanes();
        tick();
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_ready", 32'(bus.req_ready_o), 32'h2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t1_wvalid%0d", k), 32'(bus.fifo_wvalid_o), 32'd1);
        end
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_grant_end", 32'(grant), 32'd0);
        tick();
        check("t1_wvalid_off", 32'(bus.fifo_wvalid_o), 32'd0);

        // Round-robin with all four requesters holding 2-byte packets.
        do_reset();
        add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
        add_byte(0, 8'h03, 1'b0); add_byte(0, 8'h04, 1'b1);
        add_byte(1, 8'h11, 1'b0); add_byte(1, 8'h12, 1'b1);
        add_byte(2, 8'h21, 1'b0); add_byte(2, 8'h22, 1'b1);
        add_byte(3, 8'h31, 1'b0); add_byte(3, 8'h32, 1'b1);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        exp_q.push_back(8'h21); exp_q.push_back(8'h22);
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drive_lanes();
        prev_g   = '0;
        gap_viol = 0;
        n        = 0;
        while ((busy || lanes_pending()) && n < 100) begin
            tick();
            n++;
            if (grant != prev_g && grant != '0) begin
                if (prev_g != '0) gap_viol++;
                gseq.push_back(grant);
            end
            prev_g = grant;
        end
        tick();
        check("t2_budget", 32'(n < 100), 32'd1);
        check("t2_ngrants", 32'(gseq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gseq.size()) check($sformatf("t2_grant%0d", k), 32'(gseq[k]), 32'(rr_exp[k]));
            else                 check($sformatf("t2_grant%0d", k), 32'(gseq.size()), 32'(k + 1));
        end
        check("t2_arb_gap", 32'(gap_viol), 32'd0);

        // Credit: level 31 allows exactly one byte until the level drops.
        do_reset();
        bus.fifo_lvl_i = 8'd31;
        add_byte(0, 8'h51, 1'b0); add_byte(0, 8'h52, 1'b0); add_byte(0, 8'h53, 1'b1);
        exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h53);
        drive_lanes();
        tick();
        check("t3_grant", 32'(grant), 32'h1);
        check("t3_ready_credit", 32'(bus.req_ready_o), 32'h1);
        tick();
        check("t3_wvalid", 32'(bus.fifo_wvalid_o), 32'd1);
        check("t3_ready_inflight", 32'(bus.req_ready_o), 32'h0);
        tick();
        bus.fifo_lvl_i = 8'd32;
        #1;
        wr_base    = wr_cnt;
        ready_seen = 1'b0;
        terr_seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            ready_seen |= (bus.req_ready_o != '0);
            terr_seen  |= terr;
        end
        check("t3_no_writes_full", 32'(wr_cnt - wr_base), 32'd0);
        check("t3_ready_full", 32'(ready_seen), 32'd0);
        check("t3_no_timeout_full", 32'(terr_seen), 32'd0);
        check("t3_busy_full", 32'(busy), 32'd1);
        bus.fifo_lvl_i = 8'd30;
        #1;
        check("t3_ready_lvl30", 32'(bus.req_ready_o), 32'h1);
        wait_idle("t3_budget");
        check("t3_writes_after", 32'(wr_cnt - wr_base), 32'd2);
        bus.fifo_lvl_i = 8'd0;

        // Watchdog: requester 2 sends one byte then goes silent.
        do_reset();
        add_byte(2, 8'h61, 1'b0);
        exp_q.push_back(8'h61);
        drive_lanes();
        tick();
        check("t4_grant", 32'(grant), 32'h4);
        tick();
        n = 0;
        while (!terr && n < 40) begin
            tick();
            n++;
        end
        check("t4_latency", 32'(n), 32'd16);
        check("t4_id", 32'(tid), 32'd2);
        check("t4_busy", 32'(busy), 32'd0);
        tick();
        check("t4_pulse_len", 32'(terr), 32'd0);
        add_byte(3, 8'h71, 1'b1);
        add_byte(0, 8'h81, 1'b1);
        exp_q.push_back(8'h71); exp_q.push_back(8'h81);
        drive_lanes();
        tick();
        check("t4_next_grant", 32'(grant), 32'h8);
        wait_idle("t4_budget");

        // Reset mid-packet (pointer is at 1 and timeout_id at 2 going in).
        add_byte(2, 8'h91, 1'b0); add_byte(2, 8'h92, 1'b0);
        add_byte(2, 8'h93, 1'b0); add_byte(2, 8'h94, 1'b1);
        exp_q.push_back(8'h91);
        drive_lanes();
        tick();
        check("t6_grant", 32'(grant), 32'h4);
        tick();
        rst = 1'b1;
        tick();
        check("t6_grant_rst",  32'(grant), 32'd0);
        check("t6_busy_rst",   32'(busy), 32'd0);
        check("t6_ready_rst",  32'(bus.req_ready_o), 32'd0);
        check("t6_wvalid_rst", 32'(bus.fifo_wvalid_o), 32'd0);
        check("t6_wdata_rst",  32'(bus.fifo_wdata_o), 32'd0);
        check("t6_terr_rst",   32'(terr), 32'd0);
        check("t6_tid_rst",    32'(tid), 32'd0);
        clear_lanes();
        rst = 1'b0;
        add_byte(3, 8'hA1, 1'b1);
        add_byte(0, 8'hB1, 1'b1);
        exp_q.push_back(8'hB1); exp_q.push_back(8'hA1);
        drive_lanes();
        tick();
        check("t6_first_grant", 32'(grant), 32'h1);
        wait_idle("t6_budget");

        // Flush in the same cycle the watchdog would fire.
        do_reset();
        add_byte(1, 8'hC1, 1'b0);
        exp_q.push_back(8'hC1);
        drive_lanes();
        tick();
        check("t5_grant", 32'(grant), 32'h2);
        tick();
        for (int k = 0; k < TO - 1; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_terr", 32'(terr), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        check("t5_terr_after", 32'(terr), 32'd0);
        check("t5_tid", 32'(tid), 32'd0);
        add_byte(1, 8'hD1, 1'b1);
        add_byte(2, 8'hE1, 1'b1);
        exp_q.push_back(8'hD1); exp_q.push_back(8'hE1);
        drive_lanes();
        tick();
        check("t5_ptr_kept", 32'(grant), 32'h2);
        wait_idle("t5_budget");

        // Flush together with a handshake: the byte is still written.
        add_byte(0, 8'hF1, 1'b0);
        add_byte(0, 8'hF2, 1'b1);
        exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
        drive_lanes();
        tick();
        check("t7_grant", 32'(grant), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_wvalid", 32'(bus.fifo_wvalid_o), 32'd1);
        check("t7_busy", 32'(busy), 32'd0);
        wait_idle("t7_budget");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
